// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-requester main-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, requester IDs, bus widths, default burst length.
package mem_arb_pkg;

  localparam int BEATS         = 4;
  localparam int ADDR_W        = 26;
  localparam int MEM_DATA_BITS = 128;
  localparam int MASK_W        = MEM_DATA_BITS / 8;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_RRESP = 2'd3;

  // Requester IDs
  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of icache, dcache and memory-port signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: val/rdy on requests, valid/ready on write beats, none on responses.
// Modports: slave = arbiter view, master = cache/memory environment view.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic                     ic_req_val;
  logic                     ic_req_rdy;
  logic [ADDR_W-1:0]        ic_req_addr;
  logic                     ic_resp_val;
  logic [MEM_DATA_BITS-1:0] ic_resp_data;

  logic                     dc_req_val;
  logic                     dc_req_rdy;
  logic [ADDR_W-1:0]        dc_req_addr;
  logic                     dc_req_rw;
  logic                     dc_req_data_valid;
  logic                     dc_req_data_ready;
  logic [MEM_DATA_BITS-1:0] dc_req_data_bits;
  logic [MASK_W-1:0]        dc_req_data_mask;
  logic                     dc_resp_val;
  logic [MEM_DATA_BITS-1:0] dc_resp_data;

  logic                     mem_req_val;
  logic                     mem_req_rdy;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic                     mem_req_rw;
  logic                     mem_req_data_valid;
  logic                     mem_req_data_ready;
  logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
  logic [MASK_W-1:0]        mem_req_data_mask;
  logic                     mem_resp_val;
  logic [MEM_DATA_BITS-1:0] mem_resp_data;

  modport slave (
    input  ic_req_val, ic_req_addr,
    output ic_req_rdy, ic_resp_val, ic_resp_data,
    input  dc_req_val, dc_req_addr, dc_req_rw,
    input  dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
    output dc_req_rdy, dc_req_data_ready, dc_resp_val, dc_resp_data,
    output mem_req_val, mem_req_addr, mem_req_rw,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_data
  );

  modport master (
    output ic_req_val, ic_req_addr,
    input  ic_req_rdy, ic_resp_val, ic_resp_data,
    output dc_req_val, dc_req_addr, dc_req_rw,
    output dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
    input  dc_req_rdy, dc_req_data_ready, dc_resp_val, dc_resp_data,
    input  mem_req_val, mem_req_addr, mem_req_rw,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_data
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: the requester that did not win last time wins a tie.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the grant is taken.
// Ports: ic_val_i/dc_val_i requests, last_i previous winner, grant_valid_o/grant_id_o.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic ic_val_i,
  input  logic dc_val_i,
  input  logic last_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  always_comb begin
    grant_valid_o = ic_val_i | dc_val_i;
    if (ic_val_i && dc_val_i) begin
      grant_id_o = (last_i == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (dc_val_i) begin
      grant_id_o = REQ_DC;
    end else begin
      grant_id_o = REQ_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache (reads) and dcache (reads/write-backs).
// Latency: 1 cycle request-to-mem_req_val; data/response beats are zero-latency pass-through.
// Backpressure: mem_req_rdy / mem_req_data_ready passed straight to the owning cache.
// Ports: clk, reset (async active-low), bus (mem_arbiter_if.slave).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BEATS_P = BEATS
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (BEATS_P > 1) ? $clog2(BEATS_P) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_P - 1);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic gnt_vld, gnt_id;
  logic req_rw;

  mem_arb_rr u_rr (
    .ic_val_i      (bus.ic_req_val),
    .dc_val_i      (bus.dc_req_val),
    .last_i        (last_q),
    .grant_valid_o (gnt_vld),
    .grant_id_o    (gnt_id)
  );

  // icache transactions are always reads
  assign req_rw = (owner_q == REQ_DC) & bus.dc_req_rw;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    bus.ic_req_rdy         = 1'b0;
    bus.dc_req_rdy         = 1'b0;
    bus.ic_resp_val        = 1'b0;
    bus.dc_resp_val        = 1'b0;
    bus.ic_resp_data       = '0;
    bus.dc_resp_data       = '0;
    bus.dc_req_data_ready  = 1'b0;
    bus.mem_req_val        = 1'b0;
    bus.mem_req_addr       = '0;
    bus.mem_req_rw         = 1'b0;
    bus.mem_req_data_valid = 1'b0;
    bus.mem_req_data_bits  = '0;
    bus.mem_req_data_mask  = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_id;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        bus.mem_req_val  = 1'b1;
        bus.mem_req_addr = (owner_q == REQ_DC) ? bus.dc_req_addr : bus.ic_req_addr;
        bus.mem_req_rw   = req_rw;
        bus.ic_req_rdy   = (owner_q == REQ_IC) & bus.mem_req_rdy;
        bus.dc_req_rdy   = (owner_q == REQ_DC) & bus.mem_req_rdy;
        if (bus.mem_req_rdy) begin
          last_d  = owner_q;
          cnt_d   = '0;
          state_d = req_rw ? ST_WDATA : ST_RRESP;
        end
      end

      ST_WDATA: begin
        bus.mem_req_data_valid = bus.dc_req_data_valid;
        bus.mem_req_data_bits  = bus.dc_req_data_bits;
        bus.mem_req_data_mask  = bus.dc_req_data_mask;
        bus.dc_req_data_ready  = bus.mem_req_data_ready;
        if (bus.dc_req_data_valid && bus.mem_req_data_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin // ST_RRESP
        // Data is broadcast; only the owner's valid qualifies it.
        bus.ic_resp_data = bus.mem_resp_data;
        bus.dc_resp_data = bus.mem_resp_data;
        bus.ic_resp_val  = (owner_q == REQ_IC) & bus.mem_resp_val;
        bus.dc_resp_val  = (owner_q == REQ_DC) & bus.mem_resp_val;
        if (bus.mem_resp_val) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // Every output is decoded from state, so forcing IDLE zeroes them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_IC;
      last_q  <= REQ_IC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
